// File: rtl/sp_ram_fifo_pkg.sv
// Shared defaults and FSM state type for the single-port-RAM backed FIFO.
package sp_ram_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_e;

endpackage

// File: rtl/sp_ram_fifo_ram.sv
// Single-port RAM: write on we at the clock edge, read data follows the registered address.
module sp_ram
    import sp_ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        addr_q <= addr;
    end

    assign q = mem[addr_q];

endmodule

// File: rtl/sp_ram_fifo.sv
// FIFO built on one single-port RAM plus a registered head word, with empty-path bypass.
// Optional sticky overflow/underflow flags are built when SP_RAM_FIFO_ERR_EN is defined.
module sp_ram_fifo
    import sp_ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] count,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam logic [ADDR_W:0] RAM_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              rd_grant;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              ram_wr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    // in_ready depends on registered state only, so no combinational path from out_ready.
    assign rd_grant = (ram_cnt_q != '0) && !out_valid_q && (state_q == IDLE);
    assign in_ready = (ram_cnt_q != RAM_FULL) && !rd_grant;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;
    assign bypass   = push && (ram_cnt_q == '0) && (state_q == IDLE) && !out_valid_q;
    assign ram_wr   = push && !bypass;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = rd_ptr_q;
        if (ram_wr) begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr_q;
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (in_data),
        .q    (ram_q)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE:    if (rd_grant) state_d = RD;
            RD:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A write and a read grant are mutually exclusive because in_ready masks rd_grant.
        if (ram_wr) begin
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
        end
        if (rd_grant) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
        end

        if (state_q == RD) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_q;
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // The word in flight during RD is still held by the block, so it is counted.
    assign count = {1'b0, ram_cnt_q}
                 + {{(ADDR_W+1){1'b0}}, out_valid_q}
                 + {{(ADDR_W+1){1'b0}}, (state_q == RD)};
    assign full      = (ram_cnt_q == RAM_FULL);
    assign empty     = (count == '0);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SP_RAM_FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    always_comb begin
        err_ovf_d = err_ovf_q || (in_valid && full);
        err_udf_d = err_udf_q || (out_ready && !out_valid_q && (count == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_fifo.sv
// Directed plus randomized bench for sp_ram_fifo against a queue-based reference model.
module tb_sp_ram_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

`ifdef SP_RAM_FIFO_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W+1:0] count;
    logic              full;
    logic              empty;
    logic              err_ovf;
    logic              err_udf;

    sp_ram_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_push;
    logic last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the model, then check occupancy.
    task automatic cycle();
        logic [DATA_W-1:0] exp_word;
        @(negedge clk);
        last_push = 1'b0;
        last_pop  = 1'b0;
        if (!rst_n) begin
            model_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                last_pop = 1'b1;
                if (model_q.size() == 0) begin
                    chk("pop_when_empty", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_word = model_q.pop_front();
                    chk("pop_data", {24'd0, out_data}, {24'd0, exp_word});
                    $display("pop  data=%02h expected=%02h", out_data, exp_word);
                end
            end
            if (in_valid && in_ready) begin
                last_push = 1'b1;
                model_q.push_back(in_data);
                $display("push data=%02h", in_data);
            end
        end
        @(posedge clk);
        #1;
        chk("count", {26'd0, count}, model_q.size());
        chk("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50 && !done; k++) begin
            cycle();
            done = last_push;
        end
        chk("push_accepted", {31'd0, done}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int pushed;
        int guard;
        bit drained;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        last_push = 1'b0;
        last_pop  = 1'b0;
        #1;
        do_reset();

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_full",      {31'd0, full},      32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_err_ovf",   {31'd0, err_ovf},   32'd0);
        chk("rst_err_udf",   {31'd0, err_udf},   32'd0);

        // Single push into empty block goes straight to the output register
        push_word(8'hA5);
        chk("bypass_valid", {31'd0, out_valid}, 32'd1);
        chk("bypass_data",  {24'd0, out_data},  32'hA5);
        chk("bypass_count", {26'd0, count},     32'd1);

        // Fill: one bypass word plus 16 RAM words
        do_reset();
        for (int i = 0; i <= 16; i++) push_word(8'(i));
        cycle();
        chk("fill_full",     {31'd0, full},     32'd1);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_count",    {26'd0, count},    32'd17);
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_no_push", {31'd0, last_push}, 32'd0);
        end
        in_valid = 1'b0;

        // Drain in order across the pointer wrap
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            cycle();
            drained = (model_q.size() == 0);
        end
        chk("drain_done", {31'd0, drained}, 32'd1);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Random concurrent push/pop traffic
        pushed = 0;
        guard  = 0;
        in_valid = 1'b0;
        while ((pushed < 40 || model_q.size() != 0) && guard < 2000) begin
            if (last_push) pushed++;
            if (pushed < 40) begin
                if (!in_valid || last_push) begin
                    in_valid = ($urandom_range(0, 7) != 0);
                    in_data  = 8'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        if (last_push) pushed++;
        in_valid = 1'b0;
        chk("rand_pushed", pushed, 32'd40);
        chk("rand_drained", model_q.size(), 32'd0);

        // Reset while a RAM read is in flight
        out_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        out_ready = 1'b1;
        cycle();
        chk("pre_rd_pop", {31'd0, last_pop}, 32'd1);
        out_ready = 1'b0;
        cycle();
        chk("inflight_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rd_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_rst_count", {26'd0, count},     32'd0);
        push_word(8'h3C);
        chk("rd_rst_bypass_valid", {31'd0, out_valid}, 32'd1);
        chk("rd_rst_bypass_data",  {24'd0, out_data},  32'h3C);

        // Sticky error flags
        do_reset();
        for (int i = 0; i <= 16; i++) push_word(8'($urandom));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("err_ovf_set", {31'd0, err_ovf}, {31'd0, EXP_ERR});
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            cycle();
            drained = (model_q.size() == 0);
        end
        cycle();
        cycle();
        chk("err_ovf_sticky", {31'd0, err_ovf}, {31'd0, EXP_ERR});
        chk("err_udf_set",    {31'd0, err_udf}, {31'd0, EXP_ERR});
        out_ready = 1'b0;
        do_reset();
        chk("err_ovf_clr", {31'd0, err_ovf}, 32'd0);
        chk("err_udf_clr", {31'd0, err_udf}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_fifo.md
SP_RAM_FIFO -- requirements
Module: sp_ram_fifo

Interface
REQ-001 Parameter DATA_W, default 8, RAM word width.
REQ-002 Parameter ADDR_W, default 4, RAM address width; DEPTH = 2**ADDR_W (16).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  producer offers in_data.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  DATA_W  write word.
REQ-008 out_valid  output  1  out_data holds the oldest word.
REQ-009 out_ready  input  1  consumer takes out_data this cycle.
REQ-010 out_data  output  DATA_W  registered head word.
REQ-011 count  output  ADDR_W+2  words held (RAM plus output register), 0..DEPTH+1.
REQ-012 full  output  1  RAM occupancy == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 err_ovf, err_udf  output  1 each  sticky error flags (see Configuration).

Function
REQ-015 The block SHALL instantiate one sp_ram (DATA_W x DEPTH, single port: write on we at clk edge, registered address, q = mem[registered addr] one cycle after address is presented) and issue at most one RAM access per cycle.
REQ-016 Push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-017 in_ready SHALL be registered-state only: (ram_cnt != DEPTH) && !rd_grant.
REQ-018 rd_grant = (ram_cnt != 0) && !out_valid && state == IDLE; it drives addr = rd_ptr, we = 0.
REQ-019 FSM states IDLE, RD; IDLE->RD on rd_grant; RD->IDLE unconditionally, capturing q into out_data and setting out_valid.
REQ-020 In RD, pushes SHALL be permitted; write uses addr = wr_ptr, we = 1.
REQ-021 Bypass: push while ram_cnt == 0, state == IDLE and !out_valid SHALL load in_data directly into out_data (out_valid = 1 next cycle), RAM untouched.
REQ-022 Other pushes write mem[wr_ptr]; wr_ptr and ram_cnt increment.
REQ-023 rd_grant increments rd_ptr and decrements ram_cnt in the same cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH (15 -> 0) with no extra state.
REQ-025 Pop clears out_valid next cycle; out_data holds its value until next load.
REQ-026 Ordering SHALL be strict FIFO in every case, including bypass.
REQ-027 Push with in_valid && !in_ready is stalled, not dropped; producer holds data.
REQ-028 Latency: empty-block push to out_valid = 1 cycle (bypass); RAM-resident word to out_valid = 2 cycles after grant eligibility.

Reset
REQ-029 rst_n low at a rising edge SHALL clear wr_ptr, rd_ptr, ram_cnt, state (IDLE), out_valid, out_data (0), err_ovf, err_udf.
REQ-030 Reset values: in_ready = 1, out_valid = 0, count = 0, full = 0, empty = 1.
REQ-031 Reset during RD SHALL discard the in-flight read; RAM contents are not reset.

Configuration
REQ-032 Macro SP_RAM_FIFO_ERR_EN defined: err_ovf sets on in_valid && full; err_udf sets on out_ready && !out_valid && count == 0; both sticky until reset.
REQ-033 Macro undefined: err_ovf and err_udf SHALL be constant 0, no error logic.

Structure
REQ-034 Package sp_ram_fifo_pkg SHALL hold DATA_W/ADDR_W defaults, DEPTH, and the state enum (IDLE, RD).
REQ-035 Single sub-module: sp_ram, existing block, instantiated unmodified.

Verification
REQ-036 Reset, then push 0xA5 with out_ready = 0 -> out_valid = 1 next cycle, out_data = 0xA5, count = 1, RAM not written.
REQ-037 out_ready = 0, push 17 words 0x00..0x10 -> first via bypass, 16 in RAM; full = 1, in_ready = 0, count = 17; 18th in_valid stalls.
REQ-038 From REQ-037 state, out_ready = 1 -> pops 0x00..0x10 in order, empty = 1 after last; pointers wrapped 15 -> 0 correctly.
REQ-039 Continuous push and pop of 40 random words -> output equals input sequence, no loss or duplication across wrap.
REQ-040 rst_n low for one cycle while state == RD -> next cycle out_valid = 0, count = 0; next push 0x3C bypasses, out_data = 0x3C.
REQ-041 With SP_RAM_FIFO_ERR_EN: in_valid while full -> err_ovf = 1 and stays 1 until rst_n; without macro -> err_ovf = 0.
